// File: rtl/dec_counter_ctrl_pkg.sv
// Shared types and constants for the decade counter run-control block.
// State codes, direction encoding and the default terminal digit.
package dec_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int   DIGIT_MAX_DEF = 9;
    localparam logic UP            = 1'b1;
    localparam logic DOWN          = 1'b0;

endpackage

// File: rtl/dec_counter_ctrl_if.sv
// Request/strobe bundle between the debounced user inputs,
// the run-control sequencer and the decade counter datapath.
interface dec_counter_ctrl_if;

    logic       start;
    logic       stop;
    logic       clr;
    logic       dir;
    logic [3:0] dec;
    logic       dis;
    logic       cnt_en;
    logic       cnt_up;
    logic       cnt_clr;
    logic [1:0] state;
    logic       done;

    modport master (
        input  start, stop, clr, dir, dec,
        output dis, cnt_en, cnt_up, cnt_clr, state, done
    );

    modport slave (
        output start, stop, clr, dir, dec,
        input  dis, cnt_en, cnt_up, cnt_clr, state, done
    );

endinterface

// File: rtl/dec_counter_ctrl_tick_prescaler.sv
// Count-rate prescaler: tick on the last of every PRESCALE run cycles.
// Holds its count while run is low so a paused sequence resumes mid-period.
module tick_prescaler #(
    parameter int PRESCALE = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int            W    = $clog2(PRESCALE);
    localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/dec_counter_ctrl.sv
// Run-control sequencer for the 4-bit decade counter.
// Define DEC_CTRL_AUTO_WRAP_EN to keep counting through the terminal digit.
module dec_counter_ctrl
    import dec_ctrl_pkg::*;
#(
    parameter int PRESCALE  = 10,
    parameter int DIGIT_MAX = DIGIT_MAX_DEF
) (
    input logic              clk,
    input logic              reset,
    dec_counter_ctrl_if.master bus
);

`ifdef DEC_CTRL_AUTO_WRAP_EN
    localparam bit AUTO_WRAP = 1'b1;
`else
    localparam bit AUTO_WRAP = 1'b0;
`endif

    state_t state_q, state_n;
    logic   dis_q, en_q, up_q, clr_q, done_q, clr_prev;
    logic   en_n, up_n, clr_n;
    logic   run, clear, tick, terminal;

    assign run   = (state_q == RUN) && !bus.clr && !bus.stop;
    assign clear = bus.clr || ((state_q == IDLE) && bus.start);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (clear),
        .tick  (tick)
    );

    // dec above DIGIT_MAX is simply not terminal; the datapath wraps itself
    assign terminal = up_q ? (bus.dec == 4'(DIGIT_MAX))
                           : (bus.dec == 4'd0);

    always_comb begin
        state_n = state_q;
        en_n    = 1'b0;
        up_n    = up_q;
        clr_n   = bus.clr && !clr_prev;
        if ((state_q == IDLE) || (state_q == PAUSE)) begin
            up_n = bus.dir;
        end
        if (bus.clr) begin
            state_n = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) state_n = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state_n = PAUSE;
                    end else if (tick) begin
                        if (terminal && !AUTO_WRAP) state_n = DONE;
                        else                        en_n    = 1'b1;
                    end
                end
                PAUSE: begin
                    if (bus.start && !bus.stop) state_n = RUN;
                end
                DONE: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            dis_q    <= 1'b1;
            en_q     <= 1'b0;
            up_q     <= UP;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
            clr_prev <= 1'b0;
        end else begin
            state_q  <= state_n;
            dis_q    <= (state_n != RUN);
            en_q     <= en_n;
            up_q     <= up_n;
            clr_q    <= clr_n;
            done_q   <= (state_n == DONE);
            clr_prev <= bus.clr;
        end
    end

    assign bus.state   = state_q;
    assign bus.dis     = dis_q;
    assign bus.cnt_en  = en_q;
    assign bus.cnt_up  = up_q;
    assign bus.cnt_clr = clr_q;
    assign bus.done    = done_q;

endmodule
